// File: rtl/pipe_addsub_pkg.sv
// pipe_addsub_pkg: shared constants and flag bundle
// for the pipelined add/sub unit
package pipe_addsub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic lt;
    logic ltu;
  } flags_t;

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: one combinational carry slice
// also exposes the carry into its top bit
module addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ctop
);

  logic [W:0] t;

  assign t    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum  = t[W-1:0];
  assign cout = t[W];
  // a ^ b ^ sum recovers the carry that entered the top bit
  assign ctop = a[W-1] ^ b[W-1] ^ t[W-1];

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: sliced add/sub with valid/ready pipeline
// one carry slice per stage, flags decoded at the tail
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_lt,
  output logic             o_ltu
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic [STAGES:0]              rdy;
  logic [STAGES-1:0]            vld_q, sub_q, cy_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, a_q, b_q;
  logic                         cmsb_q;

  logic [STAGES-1:0]            v_up, sub_up, c_up;
  logic [STAGES-1:0]            c_sl, ct_sl;
  logic [STAGES-1:0][WIDTH-1:0] s_up, a_up, b_up, s_nx;
  logic [STAGES-1:0][SLICE-1:0] s_sl;

  flags_t fl;
  logic   unused;

  // a stage may load when empty or when its successor moves
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = i_out_ready;
    for (int k = LAST; k >= 0; k--) begin
      rdy[k] = ~vld_q[k] | rdy[k+1];
    end
  end

  always_comb begin
    v_up      = '0;
    sub_up    = '0;
    c_up      = '0;
    s_up      = '0;
    a_up      = '0;
    b_up      = '0;
    v_up[0]   = i_in_valid;
    sub_up[0] = i_sub;
    c_up[0]   = i_sub;
    a_up[0]   = i_a;
    b_up[0]   = i_sub ? ~i_b : i_b;
    for (int k = 1; k < STAGES; k++) begin
      v_up[k]   = vld_q[k-1];
      sub_up[k] = sub_q[k-1];
      c_up[k]   = cy_q[k-1];
      s_up[k]   = sum_q[k-1];
      a_up[k]   = a_q[k-1];
      b_up[k]   = b_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_sl
    addsub_slice #(
      .W (SLICE)
    ) u_sl (
      .a    (a_up[k][k*SLICE +: SLICE]),
      .b    (b_up[k][k*SLICE +: SLICE]),
      .cin  (c_up[k]),
      .sum  (s_sl[k]),
      .cout (c_sl[k]),
      .ctop (ct_sl[k])
    );
  end

  always_comb begin
    s_nx = s_up;
    for (int k = 0; k < STAGES; k++) begin
      s_nx[k][k*SLICE +: SLICE] = s_sl[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q  <= '0;
      sub_q  <= '0;
      cy_q   <= '0;
      sum_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cmsb_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= v_up[k];
          if (v_up[k]) begin
            sub_q[k] <= sub_up[k];
            cy_q[k]  <= c_sl[k];
            sum_q[k] <= s_nx[k];
            a_q[k]   <= a_up[k];
            b_q[k]   <= b_up[k];
          end
        end
      end
      if (rdy[LAST] && v_up[LAST]) begin
        cmsb_q <= ct_sl[LAST];
      end
    end
  end

  always_comb begin
    fl      = '0;
    fl.cout = cy_q[LAST];
    fl.ovf  = cy_q[LAST] ^ cmsb_q;
    fl.zero = (sum_q[LAST] == '0);
    fl.lt   = sum_q[LAST][WIDTH-1] ^ fl.ovf;
    fl.ltu  = ~cy_q[LAST];
  end

  assign o_in_ready  = rdy[0] & ~i_reset;
  assign o_out_valid = vld_q[LAST];
  assign o_sum       = sum_q[LAST];
  assign o_cout      = fl.cout;
  assign o_ovf       = fl.ovf;
  assign o_zero      = fl.zero;
  assign o_lt        = fl.lt;
  assign o_ltu       = fl.ltu;

  assign unused = ^{a_q, b_q, sub_q, ct_sl};

endmodule
